// File: rtl/tm1638_pkg.sv
// Shared constants and state type for the TM1638 device-side receiver.
package tm1638_pkg;

  // Command class, taken from byte[7:6] of the first byte of a frame
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // Data command that requests key-scan data
  localparam logic [7:0] DATA_RD_KEYS = 8'h42;

  localparam int unsigned RAM_DEPTH = 16;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StCmd,
    StDataWr,
    StKeyRd,
    StEnd
  } state_e;

endpackage

// File: rtl/tm1638_rx_if.sv
// Serial TM1638 bus: frame strobe, serial clock and the two halves of DIO.
//   stb     : frame strobe, active low (master -> device)
//   sclk    : serial clock (master -> device)
//   dio_in  : serial data from master
//   dio_out : serial key data to master
//   dio_oe  : 1 = device drives DIO
interface tm1638_rx_if;
  logic stb;
  logic sclk;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (
    output stb,
    output sclk,
    output dio_in,
    input  dio_out,
    input  dio_oe
  );

  modport slave (
    input  stb,
    input  sclk,
    input  dio_in,
    output dio_out,
    output dio_oe
  );
endinterface

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
//   clk, rst : system clock, asynchronous active-low reset
//   d        : asynchronous input pin
//   rise     : 1-cycle pulse when the synchronised level goes 0 -> 1
//   fall     : 1-cycle pulse when the synchronised level goes 1 -> 0
module tm1638_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = level;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/tm1638_rx.sv
// Device-side TM1638 frame decoder: holds the 16-byte display RAM and display
// control, and answers read-key frames by shifting key bytes out on DIO.
//   clk, rst      : system clock (>= 8x sclk), asynchronous active-low reset
//   bus           : serial bus (stb, sclk, dio_in in; dio_out, dio_oe out)
//   keys          : key-scan bytes, byte0 = keys[7:0] sent first, LSB first
//   F, S, T       : RAM[0x00], RAM[0x02], RAM[0x04]; bit0 = segment a
//   disp_on       : display-control bit 3
//   brightness    : display-control bits 2:0
//   wr_pulse      : 1-cycle pulse per committed RAM byte
//   frame_err     : 1-cycle pulse on an aborted or illegal frame
module tm1638_rx
  import tm1638_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned NUM_KEY_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  tm1638_rx_if.slave        bus,
  input  logic [31:0]       keys,
  output logic [7:0]        F,
  output logic [7:0]        S,
  output logic [7:0]        T,
  output logic              disp_on,
  output logic [2:0]        brightness,
  output logic              wr_pulse,
  output logic              frame_err
);

  localparam logic [5:0] KeyBits = 6'(NUM_KEY_BYTES * 8);

  logic stb_rise, stb_fall, sclk_rise, sclk_fall;

  // stb resets to 0 so that a high strobe after reset always shows up as a
  // rise; that rise is what releases StWaitIdle.
  tm1638_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sync_stb (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.stb),
    .rise (stb_rise),
    .fall (stb_fall)
  );

  tm1638_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Data line needs a synchroniser only; it is sampled on sclk rise.
  logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
  logic                   dio_s;

  assign dio_s = dio_sync_q[SYNC_STAGES-1];

  always_comb dio_sync_d = {dio_sync_q[SYNC_STAGES-2:0], bus.dio_in};

  state_e     state_q, state_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] addr_q, addr_d;
  logic       fixed_q, fixed_d;
  logic       disp_on_q, disp_on_d;
  logic [2:0] bright_q, bright_d;
  logic       dio_out_q, dio_out_d;
  logic       dio_oe_q, dio_oe_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] ram_d [RAM_DEPTH];
  logic [7:0] byte_next;

  // Bits arrive LSB first, so the 8th bit completes the byte on top of the
  // seven already held.
  assign byte_next = {dio_s, shift_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    fixed_d     = fixed_q;
    disp_on_d   = disp_on_q;
    bright_d    = bright_q;
    dio_out_d   = dio_out_q;
    dio_oe_d    = dio_oe_q;
    wr_pulse_d  = 1'b0;
    frame_err_d = 1'b0;
    ram_d       = ram_q;

    if (stb_rise) begin
      // Strobe rise beats any coincident sclk rise: that bit is dropped.
      if ((state_q == StCmd || state_q == StDataWr) && bit_cnt_q != 6'd0) begin
        frame_err_d = 1'b1;
      end
      state_d   = StIdle;
      bit_cnt_d = 6'd0;
      dio_oe_d  = 1'b0;
      dio_out_d = 1'b1;
    end else begin
      case (state_q)
        StWaitIdle: ;
        StIdle: begin
          if (stb_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 6'd0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            shift_d = byte_next[7:1];
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = 6'd0;
              case (byte_next[7:6])
                CMD_DATA: begin
                  if ((byte_next & DATA_RD_KEYS) == DATA_RD_KEYS) begin
                    state_d = StKeyRd;
                  end else begin
                    fixed_d = byte_next[2];
                    state_d = StEnd;
                  end
                end
                CMD_ADDR: begin
                  addr_d  = byte_next[3:0];
                  state_d = StDataWr;
                end
                CMD_DISP: begin
                  disp_on_d = byte_next[3];
                  bright_d  = byte_next[2:0];
                  state_d   = StEnd;
                end
                default: begin
                  frame_err_d = 1'b1;
                  state_d     = StEnd;
                end
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        StDataWr: begin
          if (sclk_rise) begin
            shift_d = byte_next[7:1];
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d      = 6'd0;
              ram_d[addr_q]  = byte_next;
              wr_pulse_d     = 1'b1;
              if (!fixed_q) begin
                addr_d = addr_q + 4'd1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        StKeyRd: begin
          if (sclk_fall && bit_cnt_q < KeyBits) begin
            dio_out_d = keys[bit_cnt_q[4:0]];
            dio_oe_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else if (sclk_rise && bit_cnt_q == KeyBits) begin
            // Master has sampled the last key bit; release DIO.
            dio_oe_d  = 1'b0;
            dio_out_d = 1'b1;
            state_d   = StEnd;
          end
        end
        StEnd: ;
        default: state_d = StWaitIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dio_sync_q  <= {SYNC_STAGES{1'b1}};
      state_q     <= StWaitIdle;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 7'd0;
      addr_q      <= 4'd0;
      fixed_q     <= 1'b0;
      disp_on_q   <= 1'b0;
      bright_q    <= 3'd0;
      dio_out_q   <= 1'b1;
      dio_oe_q    <= 1'b0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) begin
        ram_q[i] <= 8'h00;
      end
    end else begin
      dio_sync_q  <= dio_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      fixed_q     <= fixed_d;
      disp_on_q   <= disp_on_d;
      bright_q    <= bright_d;
      dio_out_q   <= dio_out_d;
      dio_oe_q    <= dio_oe_d;
      wr_pulse_q  <= wr_pulse_d;
      frame_err_q <= frame_err_d;
      ram_q       <= ram_d;
    end
  end

  assign F           = ram_q[0];
  assign S           = ram_q[2];
  assign T           = ram_q[4];
  assign disp_on     = disp_on_q;
  assign brightness  = bright_q;
  assign wr_pulse    = wr_pulse_q;
  assign frame_err   = frame_err_q;
  assign bus.dio_out = dio_out_q;
  assign bus.dio_oe  = dio_oe_q;

endmodule

// File: tb/tb_tm1638_rx.sv
module tb_tm1638_rx;

  localparam int HP = 60;  // serial half period: 6 system clocks

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] keys;
  logic [7:0]  F, S, T;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        wr_pulse, frame_err;

  tm1638_rx_if bus_if ();

  tm1638_rx #(
    .SYNC_STAGES   (2),
    .NUM_KEY_BYTES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .keys       (keys),
    .F          (F),
    .S          (S),
    .T          (T),
    .disp_on    (disp_on),
    .brightness (brightness),
    .wr_pulse   (wr_pulse),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the device-visible state
  logic [7:0] m_ram [16];
  logic [3:0] m_addr;
  logic       m_fixed, m_disp;
  logic [2:0] m_bright;
  int         exp_wr = 0, exp_err = 0;
  int         wr_seen = 0, err_seen = 0;
  bit         check_en = 1'b0;

  logic [7:0] fb [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_addr   = 4'd0;
    m_fixed  = 1'b0;
    m_disp   = 1'b0;
    m_bright = 3'd0;
  endtask

  // Apply one completed write-type frame: fb[0..nb-1] full bytes, then
  // 'partial' stray bits before the strobe rose.
  task automatic model_apply(input int nb, input int partial);
    logic [7:0] c;
    if (nb == 0) begin
      if (partial > 0) exp_err++;
      return;
    end
    c = fb[0];
    case (c[7:6])
      2'b01: m_fixed = c[2];
      2'b10: begin
        m_disp   = c[3];
        m_bright = c[2:0];
      end
      2'b00: exp_err++;
      default: begin
        m_addr = c[3:0];
        for (int i = 1; i < nb; i++) begin
          m_ram[m_addr] = fb[i];
          exp_wr++;
          if (!m_fixed) m_addr = (m_addr + 4'd1) % 16;
        end
        if (partial > 0) exp_err++;
      end
    endcase
  endtask

  // Single compare process: pulse counting plus steady-state checks between frames
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) wr_seen++;
    if (frame_err === 1'b1) err_seen++;
    if (check_en) begin
      chk("F", F, m_ram[0]);
      chk("S", S, m_ram[2]);
      chk("T", T, m_ram[4]);
      chk("disp_on", disp_on, m_disp);
      chk("brightness", brightness, m_bright);
      chk("dio_oe_idle", bus_if.dio_oe, 1'b0);
      chk("wr_count", wr_seen, exp_wr);
      chk("err_count", err_seen, exp_err);
    end
  end

  task automatic bit_out(input logic b);
    bus_if.sclk   = 1'b0;
    bus_if.dio_in = b;
    #HP;
    bus_if.sclk = 1'b1;
    #HP;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
  endtask

  task automatic frame_start();
    check_en = 1'b0;
    #10;
    bus_if.stb = 1'b0;
    #HP;
  endtask

  task automatic frame_end();
    bus_if.stb = 1'b1;
    #(2 * HP);
    check_en = 1'b1;
    #10;
  endtask

  task automatic write_frame(input int nb, input int partial, input logic [7:0] pbyte);
    frame_start();
    for (int i = 0; i < nb; i++) send_byte(fb[i]);
    for (int i = 0; i < partial; i++) bit_out(pbyte[i]);
    model_apply(nb, partial);
    frame_end();
  endtask

  task automatic key_frame(input logic [31:0] k, input int nclk);
    keys = k;
    frame_start();
    send_byte(8'h42);
    bus_if.dio_in = 1'b1;
    for (int i = 0; i < nclk; i++) begin
      bus_if.sclk = 1'b0;
      #HP;
      if (i < 32) begin
        chk("key_oe", bus_if.dio_oe, 1'b1);
        chk("key_bit", bus_if.dio_out, k[i]);
      end else begin
        chk("key_extra_oe", bus_if.dio_oe, 1'b0);
        chk("key_extra_out", bus_if.dio_out, 1'b1);
      end
      bus_if.sclk = 1'b1;
      #HP;
    end
    frame_end();
    chk("key_oe_after", bus_if.dio_oe, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, e0;
    logic [7:0] r;
    bus_if.stb    = 1'b1;
    bus_if.sclk   = 1'b1;
    bus_if.dio_in = 1'b1;
    keys          = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #(2 * HP);

    // Reset state
    chk("rst_F", F, 8'h00);
    chk("rst_S", S, 8'h00);
    chk("rst_T", T, 8'h00);
    chk("rst_disp", disp_on, 1'b0);
    chk("rst_bright", brightness, 3'd0);
    chk("rst_oe", bus_if.dio_oe, 1'b0);
    chk("rst_out", bus_if.dio_out, 1'b1);
    chk("rst_wr", wr_pulse, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    check_en = 1'b1;

    // Auto-increment write across F/S/T
    w0 = wr_seen;
    fb[0] = 8'h40; write_frame(1, 0, 8'h00);
    fb[0] = 8'hC0; fb[1] = 8'hDA; fb[2] = 8'h00; fb[3] = 8'h60; fb[4] = 8'h00; fb[5] = 8'hE0;
    write_frame(6, 0, 8'h00);
    chk("t1_F", F, 8'hDA);
    chk("t1_S", S, 8'h60);
    chk("t1_T", T, 8'hE0);
    chk("t1_wr", wr_seen - w0, 5);

    // Fixed address: second byte overwrites RAM[2]
    fb[0] = 8'h44; write_frame(1, 0, 8'h00);
    fb[0] = 8'hC2; fb[1] = 8'h5B; fb[2] = 8'h6D; write_frame(3, 0, 8'h00);
    chk("t2_S", S, 8'h6D);
    chk("t2_F", F, 8'hDA);

    // Display control
    fb[0] = 8'h8F; write_frame(1, 0, 8'h00);
    chk("t3_disp_on", disp_on, 1'b1);
    chk("t3_bright", brightness, 3'd7);
    fb[0] = 8'h80; write_frame(1, 0, 8'h00);
    chk("t3_disp_off", disp_on, 1'b0);
    chk("t3_bright0", brightness, 3'd0);

    // Key read
    key_frame(32'h0000_0081, 32);

    // Address wrap 0x0F -> 0x00
    fb[0] = 8'h40; write_frame(1, 0, 8'h00);
    fb[0] = 8'hCF; fb[1] = 8'h11; fb[2] = 8'h22; write_frame(3, 0, 8'h00);
    chk("t5_F", F, 8'h22);

    // Aborted data byte after 5 bits
    e0 = err_seen;
    fb[0] = 8'hC0; write_frame(1, 5, 8'hFF);
    chk("t6_err", err_seen - e0, 1);
    chk("t6_F", F, 8'h22);

    // Illegal command and zero-byte frame
    e0 = err_seen;
    fb[0] = 8'h15; write_frame(1, 0, 8'h00);
    chk("illegal_err", err_seen - e0, 1);
    e0 = err_seen;
    write_frame(0, 0, 8'h00);
    chk("zero_frame_err", err_seen - e0, 0);

    // Reset mid-frame: outputs clear, rest of frame ignored
    fb[0] = 8'h8A; write_frame(1, 0, 8'h00);
    w0 = wr_seen;
    e0 = err_seen;
    frame_start();
    send_byte(8'hC0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    rst = 1'b0;
    #30;
    model_reset();
    chk("mid_rst_F", F, 8'h00);
    chk("mid_rst_disp", disp_on, 1'b0);
    chk("mid_rst_oe", bus_if.dio_oe, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    send_byte(8'h77);
    frame_end();
    chk("mid_rst_wr", wr_seen - w0, 0);
    chk("mid_rst_err", err_seen - e0, 0);
    chk("mid_rst_F_after", F, 8'h00);

    // Randomised frames against the model
    for (int n = 0; n < 50; n++) begin
      int kind, nb, partial;
      kind = $urandom_range(0, 5);
      r    = 8'($urandom);
      case (kind)
        0: begin
          fb[0] = {2'b01, r[5:2], 1'b0, r[0]};
          write_frame(1, 0, 8'h00);
        end
        1: begin
          fb[0] = {2'b11, r[5:0]};
          nb = 1 + $urandom_range(1, 5);
          for (int i = 1; i < nb; i++) fb[i] = 8'($urandom);
          partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
          write_frame(nb, partial, 8'($urandom));
        end
        2: begin
          fb[0] = {2'b10, r[5:0]};
          write_frame(1, 0, 8'h00);
        end
        3: begin
          fb[0] = {2'b00, r[5:0]};
          nb = 1 + $urandom_range(0, 2);
          for (int i = 1; i < nb; i++) fb[i] = 8'($urandom);
          write_frame(nb, 0, 8'h00);
        end
        4: key_frame($urandom, 32 + $urandom_range(0, 3));
        default: write_frame(0, $urandom_range(0, 7), 8'($urandom));
      endcase
    end

    check_en = 1'b0;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
